// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the two-way intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_A,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_B,
    FLASH
  } state_t;

  // Lights are {R,Y,G}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

endpackage

// File: rtl/sec_tick_sync.sv
// Brings the 1 Hz divider output into the system clock domain and emits a
// single-cycle tick on each rising edge.
module sec_tick_sync (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic clk_1Hz,
  output logic tick
);

  logic s1, s2, s3;

  // Reset to 1 so a high clk_1Hz level after reset never looks like an edge.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= clk_1Hz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

endmodule

// File: rtl/traffic_light_ctrl.sv
// NS/EW intersection sequencer with per-second countdown, pedestrian
// green-shortening and flashing-yellow maintenance mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_SEC  = 10,
  parameter int unsigned YELLOW_SEC = 3,
  parameter int unsigned ALLRED_SEC = 1,
  parameter int unsigned PED_SEC    = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             clk_1Hz,
  input  logic             enable,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] remain_sec,
  output logic             ped_pend
);

  if (GREEN_SEC < 1 || YELLOW_SEC < 1 || ALLRED_SEC < 1) begin : g_bad_duration
    $error("phase durations must be at least one second");
  end
  if (PED_SEC < 1 || PED_SEC >= GREEN_SEC) begin : g_bad_ped
    $error("PED_SEC must be in [1, GREEN_SEC)");
  end
  if (GREEN_SEC >= 2**CNT_W || YELLOW_SEC >= 2**CNT_W || ALLRED_SEC >= 2**CNT_W) begin : g_bad_w
    $error("CNT_W too narrow for the longest phase");
  end

  state_t state;
  logic   flash_ph;
  logic   tick;
  logic   is_green;

  sec_tick_sync u_sec_tick_sync (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .clk_1Hz  (clk_1Hz),
    .tick     (tick)
  );

  assign is_green = (state == NS_GREEN) || (state == EW_GREEN);

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state      <= NS_GREEN;
      remain_sec <= CNT_W'(GREEN_SEC);
      ns_light   <= L_GRN;
      ew_light   <= L_RED;
      ped_pend   <= 1'b0;
      flash_ph   <= 1'b0;
    end else if (!enable) begin
      // Maintenance mode wins over any tick in the same cycle.
      state      <= FLASH;
      remain_sec <= '0;
      ped_pend   <= 1'b0;
      if (state != FLASH) begin
        flash_ph <= 1'b0;
        ns_light <= L_OFF;
        ew_light <= L_OFF;
      end else if (tick) begin
        flash_ph <= ~flash_ph;
        ns_light <= flash_ph ? L_OFF : L_YEL;
        ew_light <= flash_ph ? L_OFF : L_YEL;
      end
    end else if (state == FLASH) begin
      state      <= ALLRED_B;
      remain_sec <= CNT_W'(ALLRED_SEC);
      ns_light   <= L_RED;
      ew_light   <= L_RED;
      flash_ph   <= 1'b0;
    end else begin
      ped_pend <= ped_pend | ped_req;
      if (tick) begin
        if (remain_sec == CNT_W'(1)) begin
          case (state)
            NS_GREEN: begin
              state      <= NS_YELLOW;
              remain_sec <= CNT_W'(YELLOW_SEC);
              ns_light   <= L_YEL;
              ew_light   <= L_RED;
              ped_pend   <= 1'b0;
            end
            NS_YELLOW: begin
              state      <= ALLRED_A;
              remain_sec <= CNT_W'(ALLRED_SEC);
              ns_light   <= L_RED;
              ew_light   <= L_RED;
            end
            ALLRED_A: begin
              state      <= EW_GREEN;
              remain_sec <= CNT_W'(GREEN_SEC);
              ns_light   <= L_RED;
              ew_light   <= L_GRN;
            end
            EW_GREEN: begin
              state      <= EW_YELLOW;
              remain_sec <= CNT_W'(YELLOW_SEC);
              ns_light   <= L_RED;
              ew_light   <= L_YEL;
              ped_pend   <= 1'b0;
            end
            EW_YELLOW: begin
              state      <= ALLRED_B;
              remain_sec <= CNT_W'(ALLRED_SEC);
              ns_light   <= L_RED;
              ew_light   <= L_RED;
            end
            default: begin
              state      <= NS_GREEN;
              remain_sec <= CNT_W'(GREEN_SEC);
              ns_light   <= L_GRN;
              ew_light   <= L_RED;
            end
          endcase
        end else if (is_green && (ped_pend || ped_req) &&
                     ((remain_sec - CNT_W'(1)) > CNT_W'(PED_SEC))) begin
          remain_sec <= CNT_W'(PED_SEC);
        end else begin
          remain_sec <= remain_sec - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed scoreboard bench for traffic_light_ctrl: expected outputs are queued
// as each stimulus step is driven and compared once the DUT has responded.
module tb_traffic_light_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  logic       clk_50MHz = 1'b0;
  logic       reset     = 1'b0;
  logic       clk_1Hz   = 1'b1;
  logic       enable    = 1'b1;
  logic       ped_req   = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [7:0] remain_sec;
  logic       ped_pend;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic [7:0] remain;
    logic       ped;
  } exp_t;

  exp_t sb[$];

  traffic_light_ctrl dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .clk_1Hz   (clk_1Hz),
    .enable    (enable),
    .ped_req   (ped_req),
    .ns_light  (ns_light),
    .ew_light  (ew_light),
    .remain_sec(remain_sec),
    .ped_pend  (ped_pend)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] ns, input logic [2:0] ew, input int remain,
                      input logic ped);
    exp_t e;
    e.ns     = ns;
    e.ew     = ew;
    e.remain = 8'(remain);
    e.ped    = ped;
    sb.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".ns"}, {5'b0, ns_light}, {5'b0, e.ns});
      cmp({tag, ".ew"}, {5'b0, ew_light}, {5'b0, e.ew});
      cmp({tag, ".remain"}, remain_sec, e.remain);
      cmp({tag, ".ped"}, {7'b0, ped_pend}, {7'b0, e.ped});
    end
  endtask

  // One 1 Hz rising edge; outputs have settled by the final negedge.
  task automatic do_tick();
    @(negedge clk_50MHz) clk_1Hz = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    clk_1Hz = 1'b1;
    repeat (4) @(negedge clk_50MHz);
  endtask

  task automatic tick_expect(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                             input int remain, input logic ped);
    push(ns, ew, remain, ped);
    do_tick();
    check(tag);
  endtask

  task automatic run(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                     input int from, input int to, input logic ped);
    for (int r = from; r >= to; r--) tick_expect(tag, ns, ew, r, ped);
  endtask

  task automatic ped_pulse();
    @(negedge clk_50MHz) ped_req = 1'b1;
    @(negedge clk_50MHz) ped_req = 1'b0;
  endtask

  initial begin
    int         dur [6] = '{10, 3, 1, 10, 3, 1};
    logic [2:0] nsl [6] = '{G, Y, R, R, R, R};
    logic [2:0] ewl [6] = '{R, R, R, G, Y, R};
    int         fp [28];
    int         fr [28];
    int         k;

    // Reset with clk_1Hz held high: no spurious tick.
    repeat (3) @(negedge clk_50MHz);
    reset = 1'b1;
    @(negedge clk_50MHz);
    push(G, R, 10, 1'b0);
    check("reset");
    repeat (20) @(negedge clk_50MHz);
    push(G, R, 10, 1'b0);
    check("no_tick");

    // Full cycle of 28 ticks.
    k = 0;
    for (int p = 0; p < 6; p++) begin
      for (int r = dur[p]; r >= 1; r--) begin
        fp[k] = p;
        fr[k] = r;
        k++;
      end
    end
    for (int t = 1; t <= 28; t++) begin
      tick_expect("cycle", nsl[fp[t % 28]], ewl[fp[t % 28]], fr[t % 28], 1'b0);
    end

    // Pedestrian clamp during NS green.
    run("ns_green", G, R, 9, 8, 1'b0);
    ped_pulse();
    push(G, R, 8, 1'b1);
    check("ped_latch");
    tick_expect("ped_clamp", G, R, 3, 1'b1);
    run("ped_count", G, R, 2, 1, 1'b1);
    tick_expect("ped_clear", Y, R, 3, 1'b0);

    // Late request in green does not clamp; request in yellow shortens next green.
    run("ns_yel", Y, R, 2, 1, 1'b0);
    tick_expect("allred_a", R, R, 1, 1'b0);
    tick_expect("ew_green", R, G, 10, 1'b0);
    run("ew_green", R, G, 9, 3, 1'b0);
    ped_pulse();
    push(R, G, 3, 1'b1);
    check("ped_late_latch");
    tick_expect("no_clamp", R, G, 2, 1'b1);
    tick_expect("no_clamp1", R, G, 1, 1'b1);
    tick_expect("ew_yel_clr", R, Y, 3, 1'b0);
    ped_pulse();
    push(R, Y, 3, 1'b1);
    check("ped_in_yel");
    run("ew_yel_hold", R, Y, 2, 1, 1'b1);
    tick_expect("allred_hold", R, R, 1, 1'b1);
    tick_expect("ns_green_pend", G, R, 10, 1'b1);
    tick_expect("late_clamp", G, R, 3, 1'b1);
    run("late_count", G, R, 2, 1, 1'b1);
    tick_expect("ns_yel2", Y, R, 3, 1'b0);
    run("ns_yel2", Y, R, 2, 1, 1'b0);
    tick_expect("allred_a2", R, R, 1, 1'b0);
    tick_expect("ew_green2", R, G, 10, 1'b0);
    run("ew_green2", R, G, 9, 1, 1'b0);
    tick_expect("ew_yel2", R, Y, 3, 1'b0);
    tick_expect("ew_yel2", R, Y, 2, 1'b0);

    // Disable coincident with a tick: flash wins.
    @(negedge clk_50MHz) clk_1Hz = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    clk_1Hz = 1'b1;
    @(negedge clk_50MHz);
    @(negedge clk_50MHz);
    enable = 1'b0;
    push(O, O, 0, 1'b0);
    @(negedge clk_50MHz);
    check("flash_entry");
    tick_expect("flash_on", Y, Y, 0, 1'b0);
    tick_expect("flash_off", O, O, 0, 1'b0);
    tick_expect("flash_on2", Y, Y, 0, 1'b0);
    enable = 1'b1;
    push(R, R, 1, 1'b0);
    @(negedge clk_50MHz);
    check("flash_exit");
    tick_expect("flash_ns_green", G, R, 10, 1'b0);

    // Asynchronous reset mid EW green.
    run("to_ew", G, R, 9, 1, 1'b0);
    tick_expect("to_ew_y", Y, R, 3, 1'b0);
    run("to_ew_y", Y, R, 2, 1, 1'b0);
    tick_expect("to_ew_a", R, R, 1, 1'b0);
    tick_expect("to_ew_g", R, G, 10, 1'b0);
    run("to_ew_g", R, G, 9, 5, 1'b0);
    @(negedge clk_50MHz);
    #2 reset = 1'b0;
    push(G, R, 10, 1'b0);
    #2 check("async_reset");
    @(negedge clk_50MHz) reset = 1'b1;
    tick_expect("post_reset", G, R, 9, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
